// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu3 pipeline front end.
// The fetch-queue entry pairs a fetched word with the PC it came from.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [5:0]         OP_HALT   = 6'h3F;
  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries between imem and decode.
// A flush empties the queue and overrides any push or pop in the same cycle.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers returned words so a decode stall never loses an in-flight fetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                BITS     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                FQ_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [BITS-1:0]   imem_rdata,
  input  logic              stall_s2,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [BITS-1:0]   instr_s2,
  output logic [ADDR_W-1:0] pc_s2,
  output logic              valid_s2,
  output logic              halt,
  output logic              exception
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag;
  logic              inflight;
  fq_entry_t         head;
  fq_entry_t         push_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              flush;
  logic              halt_pop;
  logic              credit_ok;
  logic              issue;

  assign valid_s2 = !empty;
  assign instr_s2 = valid_s2 ? head.instr : INSTR_NOP;
  assign pc_s2    = valid_s2 ? head.pc : '0;
  assign pop      = valid_s2 && !stall_s2;

  // A popped HALT on a redirect cycle is wrong-path, so it must not stop fetch.
  assign halt_pop = pop && !redirect && (head.instr[INSTR_W-1 -: 6] == OP_HALT);

  // Counting this cycle's pop as a freed slot keeps one fetch per cycle
  // flowing while decode accepts; the return still can never overflow.
  assign credit_ok = (int'(count) + int'(inflight) - int'(pop)) < FQ_DEPTH;

  assign issue = rst_ && !halt && !exception && !redirect && !halt_pop && credit_ok;

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign push_data = '{instr: imem_rdata, pc: tag};
  assign push      = inflight && !halt && (!full || pop);
  assign flush     = redirect || halt_pop;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_     (rst_),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  // A misaligned redirect target leaves the PC alone and latches the exception.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc        <= RESET_PC;
      tag       <= '0;
      inflight  <= 1'b0;
      halt      <= 1'b0;
      exception <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) tag <= pc;
      if (redirect) begin
        if (redirect_pc[1:0] == 2'b00) pc <= redirect_pc;
        else                           exception <= 1'b1;
      end else if (issue) begin
        pc <= pc + ADDR_W'(4);
      end
      if (halt_pop) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line fetch, stall, redirect,
// misaligned redirect, async reset and PC wrap-around (second instance).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_;
  logic        stall_s2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_s2;
  logic [31:0] pc_s2;
  logic        valid_s2;
  logic        halt;
  logic        exception;

  logic        w_stall = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_instr_s2;
  logic [31:0] w_pc_s2;
  logic        w_valid_s2;
  logic        w_halt;
  logic        w_exception;

  logic [31:0] imem [32];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk        (clk),
    .rst_       (rst_),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall_s2   (stall_s2),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_s2   (instr_s2),
    .pc_s2      (pc_s2),
    .valid_s2   (valid_s2),
    .halt       (halt),
    .exception  (exception)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk        (clk),
    .rst_       (rst_),
    .imem_req   (w_imem_req),
    .imem_addr  (w_imem_addr),
    .imem_rdata (w_imem_rdata),
    .stall_s2   (w_stall),
    .redirect   (w_redirect),
    .redirect_pc(w_redirect_pc),
    .instr_s2   (w_instr_s2),
    .pc_s2      (w_pc_s2),
    .valid_s2   (w_valid_s2),
    .halt       (w_halt),
    .exception  (w_exception)
  );

  // Synchronous instruction memories with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem[imem_addr[6:2]];
    if (w_imem_req) w_imem_rdata <= {16'hA5A5, w_imem_addr[15:0]};
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] p);
    @(negedge clk);
    stall_s2    = s;
    redirect    = r;
    redirect_pc = p;
    #1;
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_        = 1'b0;
    stall_s2    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    check_output({tag, "_valid"}, 64'(valid_s2), 64'h0);
    check_output({tag, "_instr"}, 64'(instr_s2), 64'h0);
    check_output({tag, "_pc"}, 64'(pc_s2), 64'h0);
    check_output({tag, "_req"}, 64'(imem_req), 64'h0);
    check_output({tag, "_halt"}, 64'(halt), 64'h0);
    check_output({tag, "_exc"}, 64'(exception), 64'h0);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_ = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h1100_0000 | i;
    imem[0] = 32'h2001_0005;
    imem[1] = 32'h2002_0003;
    imem[2] = 32'h0022_1820;
    imem[3] = 32'hFC00_0000;
    rst_        = 1'b0;
    stall_s2    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_valid", 64'(valid_s2), 64'h0);
    check_output("rst_instr", 64'(instr_s2), 64'h0);
    check_output("rst_pc", 64'(pc_s2), 64'h0);
    check_output("rst_req", 64'(imem_req), 64'h0);
    check_output("rst_halt", 64'(halt), 64'h0);
    check_output("rst_exc", 64'(exception), 64'h0);

    $display("[TB] straight line to HALT, plus wrap instance");
    release_reset();
    check_output("sl_req0", 64'(imem_req), 64'h1);
    check_output("sl_addr0", 64'(imem_addr), 64'h0);
    check_output("wrap_addr0", 64'(w_imem_addr), 64'hFFFF_FFFC);
    step(0, 0, 0);
    check_output("sl_valid1", 64'(valid_s2), 64'h0);
    check_output("sl_addr1", 64'(imem_addr), 64'h4);
    check_output("wrap_addr1", 64'(w_imem_addr), 64'h0);
    step(0, 0, 0);
    check_output("sl_valid2", 64'(valid_s2), 64'h1);
    check_output("sl_pc2", 64'(pc_s2), 64'h0);
    check_output("sl_instr2", 64'(instr_s2), 64'h2001_0005);
    check_output("wrap_pc2", 64'(w_pc_s2), 64'hFFFF_FFFC);
    check_output("wrap_instr2", 64'(w_instr_s2), 64'hA5A5_FFFC);
    step(0, 0, 0);
    check_output("sl_pc3", 64'(pc_s2), 64'h4);
    check_output("sl_instr3", 64'(instr_s2), 64'h2002_0003);
    check_output("wrap_pc3", 64'(w_pc_s2), 64'h0);
    check_output("wrap_instr3", 64'(w_instr_s2), 64'hA5A5_0000);
    step(0, 0, 0);
    check_output("sl_pc4", 64'(pc_s2), 64'h8);
    check_output("sl_instr4", 64'(instr_s2), 64'h0022_1820);
    step(0, 0, 0);
    check_output("sl_pc5", 64'(pc_s2), 64'hC);
    check_output("sl_instr5", 64'(instr_s2), 64'hFC00_0000);
    check_output("sl_halt5", 64'(halt), 64'h0);
    check_output("sl_req5", 64'(imem_req), 64'h0);
    step(0, 0, 0);
    check_output("sl_halt6", 64'(halt), 64'h1);
    check_output("sl_valid6", 64'(valid_s2), 64'h0);
    check_output("sl_req6", 64'(imem_req), 64'h0);
    step(0, 0, 0);
    check_output("sl_req7", 64'(imem_req), 64'h0);
    check_output("sl_instr7", 64'(instr_s2), 64'h0);

    $display("[TB] stall at pc 4");
    do_reset("rst_after_halt");
    release_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    check_output("st_pc0", 64'(pc_s2), 64'h0);
    step(1, 0, 0);
    check_output("st_pc_a", 64'(pc_s2), 64'h4);
    check_output("st_instr_a", 64'(instr_s2), 64'h2002_0003);
    check_output("st_req_a", 64'(imem_req), 64'h0);
    step(1, 0, 0);
    check_output("st_pc_b", 64'(pc_s2), 64'h4);
    check_output("st_req_b", 64'(imem_req), 64'h0);
    step(1, 0, 0);
    check_output("st_pc_c", 64'(pc_s2), 64'h4);
    check_output("st_valid_c", 64'(valid_s2), 64'h1);
    check_output("st_req_c", 64'(imem_req), 64'h0);
    step(0, 0, 0);
    check_output("st_pc_rel", 64'(pc_s2), 64'h4);
    check_output("st_req_rel", 64'(imem_req), 64'h1);
    check_output("st_addr_rel", 64'(imem_addr), 64'hC);
    step(0, 0, 0);
    check_output("st_pc8", 64'(pc_s2), 64'h8);
    check_output("st_addr10", 64'(imem_addr), 64'h10);
    step(0, 0, 0);
    check_output("st_pcC", 64'(pc_s2), 64'hC);
    check_output("st_instrC", 64'(instr_s2), 64'hFC00_0000);
    step(0, 0, 0);
    check_output("st_halt", 64'(halt), 64'h1);

    $display("[TB] redirect with read in flight, then misaligned redirect");
    do_reset("rst_before_redir");
    release_reset();
    step(0, 0, 0);
    step(1, 1, 32'h40);
    check_output("rd_req_on_redir", 64'(imem_req), 64'h0);
    check_output("rd_pc_on_redir", 64'(pc_s2), 64'h0);
    step(0, 0, 0);
    check_output("rd_valid_flush", 64'(valid_s2), 64'h0);
    check_output("rd_req_new", 64'(imem_req), 64'h1);
    check_output("rd_addr_new", 64'(imem_addr), 64'h40);
    step(0, 0, 0);
    check_output("rd_valid_gap", 64'(valid_s2), 64'h0);
    check_output("rd_addr44", 64'(imem_addr), 64'h44);
    step(0, 0, 0);
    check_output("rd_pc40", 64'(pc_s2), 64'h40);
    check_output("rd_instr40", 64'(instr_s2), 64'h1100_0010);
    step(0, 0, 0);
    check_output("rd_pc44", 64'(pc_s2), 64'h44);
    step(0, 1, 32'h42);
    check_output("ex_req_on_redir", 64'(imem_req), 64'h0);
    step(0, 0, 0);
    check_output("ex_flag", 64'(exception), 64'h1);
    check_output("ex_valid", 64'(valid_s2), 64'h0);
    check_output("ex_req", 64'(imem_req), 64'h0);
    step(0, 0, 0);
    check_output("ex_req_later", 64'(imem_req), 64'h0);
    check_output("ex_flag_later", 64'(exception), 64'h1);

    $display("[TB] async reset mid-stream");
    do_reset("rst_after_exc");
    release_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_output("ms_pc4", 64'(pc_s2), 64'h4);
    do_reset("rst_midstream");
    release_reset();
    check_output("ms_restart_addr", 64'(imem_addr), 64'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_output("ms_restart_pc", 64'(pc_s2), 64'h0);
    check_output("ms_restart_instr", 64'(instr_s2), 64'h2001_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
